// File: rtl/wishbone_slave_if.sv
// wishbone_if: Wishbone pipelined-mode bus bundle.
//   cyc_i   - bus cycle active
//   stb_i   - request strobe
//   we_i    - 1 = write, 0 = read
//   adr_i   - address (ADDR_WIDTH)
//   dat_i   - write data (DATA_WIDTH)
//   dat_o   - read data (DATA_WIDTH)
//   ack_o   - transfer complete
//   stall_o - request not accepted this cycle
// Modport 'slave' is the view of the responding block; 'master' is the view
// of the initiator.
interface wishbone_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_o;
  logic                  stall_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o, stall_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o, stall_o
  );
endinterface

// File: rtl/wishbone_slave.sv
// wishbone_slave: single-outstanding Wishbone slave that bridges bus
// transfers onto a simple fixed-latency backing store.
//
// Ports:
//   clk        - clock, all logic on the rising edge
//   rst        - asynchronous active-high reset
//   wb_slave   - Wishbone slave side (cyc/stb/we/adr/dat in, dat/ack/stall out)
//   mem_addr   - backing-store address, registered at accept
//   mem_wdata  - backing-store write data, registered at accept
//   mem_we     - one-cycle write strobe
//   mem_re     - one-cycle read strobe
//   mem_rdata  - read data, sampled MEM_LATENCY cycles after mem_re
//   busy       - high whenever a transfer is in progress
//
// Timing (edges counted from the accepting edge):
//   write: WRITE (mem_we) -> RESPOND (ack), ack seen at edge +2
//   read : READ_WAIT for MEM_LATENCY+1 cycles (mem_re in the first) ->
//          RESPOND (ack, dat_o valid), ack seen at edge MEM_LATENCY+2
module wishbone_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  wishbone_if.slave             wb_slave,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam logic [3:0] LAT = MEM_LATENCY[3:0];

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    RESPOND   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [3:0]            cnt_q,   cnt_d;
  // Cleared by reset, set one edge later: blocks an accept on the edge
  // that immediately follows reset release.
  logic                  arm_q,   arm_d;

  logic accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    arm_d   = 1'b1;
    accept  = (state_q == IDLE) && arm_q && wb_slave.cyc_i && wb_slave.stb_i;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          addr_d = wb_slave.adr_i;
          if (wb_slave.we_i) begin
            wdata_d = wb_slave.dat_i;
            state_d = WRITE;
          end else begin
            state_d = READ_WAIT;
          end
        end
      end
      WRITE: begin
        // mem_we fires this cycle regardless; a dropped cyc only skips the ack.
        state_d = wb_slave.cyc_i ? RESPOND : IDLE;
      end
      READ_WAIT: begin
        if (!wb_slave.cyc_i) begin
          // Abandon the read; dat_o keeps its previous value.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAT) begin
          rdata_d = mem_rdata;
          state_d = RESPOND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy             = (state_q != IDLE);
  assign wb_slave.stall_o = (state_q != IDLE);
  assign wb_slave.ack_o   = (state_q == RESPOND) && wb_slave.cyc_i;
  assign wb_slave.dat_o   = rdata_q;
  assign mem_we           = (state_q == WRITE);
  // Counter is zero only in the first READ_WAIT cycle.
  assign mem_re           = (state_q == READ_WAIT) && (cnt_q == 4'd0);
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;

endmodule
